master_port_rw: RTL

//  Parametrised serial bus master port with read and write support. Sits between a

---
 rtl/master_port_rw_pkg.sv | 22 ++
 rtl/master_port_rw_if.sv | 69 ++++++
 rtl/master_port_rw_serial_shifter.sv | 42 ++++
 rtl/master_port_rw.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/master_port_rw_pkg.sv
// Shared types and constants for the serial bus master port.
// Imported by the port top level.
package master_port_rw_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StAddr,
      StWait,
      StWdata,
      StRdata,
      StDone
   } state_e;

   localparam logic ModeRead  = 1'b0;
   localparam logic ModeWrite = 1'b1;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/master_port_rw_if.sv
// Local request handshake plus serial system bus signals of one master port.
// The master modport is the port's own view; slave is the surrounding system.
interface master_port_rw_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) ();

   // Local master side
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_wen;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_rdata;
   logic              m_done;
   logic              m_err;

   // Serial system bus side
   logic              mp_breq;
   logic              mp_bgnt;
   logic              mp_addr;
   logic              mp_wdata;
   logic              mp_mode;
   logic              mp_valid;
   logic              mp_ready;
   logic              mp_rdata;
   logic              mp_rvalid;

   modport master (
      input  m_addr,
      input  m_wdata,
      input  m_wen,
      input  m_valid,
      output m_ready,
      output m_rdata,
      output m_done,
      output m_err,
      output mp_breq,
      input  mp_bgnt,
      output mp_addr,
      output mp_wdata,
      output mp_mode,
      output mp_valid,
      input  mp_ready,
      input  mp_rdata,
      input  mp_rvalid
   );

   modport slave (
      output m_addr,
      output m_wdata,
      output m_wen,
      output m_valid,
      input  m_ready,
      input  m_rdata,
      input  m_done,
      input  m_err,
      input  mp_breq,
      output mp_bgnt,
      input  mp_addr,
      input  mp_wdata,
      input  mp_mode,
      input  mp_valid,
      output mp_ready,
      output mp_rdata,
      output mp_rvalid
   );

endinterface

// File: rtl/master_port_rw_serial_shifter.sv
// LSB-first serial shifter with parallel load, shift-in at the MSB and a bit counter
// whose done flag marks the bit currently at the output as the last one.
module master_port_rw_serial_shifter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             shift_in,
   input  logic [CNT_W-1:0] last_idx,
   output logic [WIDTH-1:0] data_next,
   output logic             bit_out,
   output logic             done
);

   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   ext;

   // Widening by one bit keeps the shift well-formed even for WIDTH == 1.
   assign ext       = {shift_in, data_q};
   assign data_next = ext[WIDTH:1];
   assign bit_out   = data_q[0];
   assign done      = (cnt_q == last_idx);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         data_q <= load_data;
         cnt_q  <= '0;
      end else if (shift_en) begin
         data_q <= data_next;
         cnt_q  <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/master_port_rw.sv
// Serial bus master port: takes a parallel read/write request, wins the bus and shifts
// address and data LSB-first, retrying on grant loss and aborting on slave timeout.
module master_port_rw
   import master_port_rw_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input logic              clk,
   input logic              rstn,
   master_port_rw_if.master bus
);

   localparam int unsigned ShW   = max_u(ADDR_W, DATA_W);
   localparam int unsigned CntW  = (ShW > 1) ? $clog2(ShW) : 1;
   localparam int unsigned ToW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_W - 1);
   localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);

   state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wen_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ToW-1:0]    to_cnt_q, to_cnt_d;
   logic              to_hit;
   logic              accept;
   logic              busy_bus;

   logic              wr_load;
   logic [ShW-1:0]    wr_load_data;
   logic              wr_shift;
   logic [CntW-1:0]   wr_last;
   logic [ShW-1:0]    wr_next;
   logic              wr_bit;
   logic              wr_done;

   logic              rd_load;
   logic              rd_shift;
   logic              rd_capture;
   logic [DATA_W-1:0] rd_next;
   logic              rd_bit;
   logic              rd_done;
   logic              unused_sh;

   assign accept  = (state_q == StIdle) && bus.m_valid;
   assign to_hit  = (TIMEOUT != 0) && (to_cnt_q == ToW'(TIMEOUT));
   assign wr_last = (state_q == StWdata) ? DataLast : AddrLast;

   // Address and write data share one shifter; the read shifter collects mp_rdata.
   master_port_rw_serial_shifter #(
      .WIDTH (ShW),
      .CNT_W (CntW)
   ) u_wr_shifter (
      .clk       (clk),
      .rstn      (rstn),
      .load      (wr_load),
      .load_data (wr_load_data),
      .shift_en  (wr_shift),
      .shift_in  (1'b0),
      .last_idx  (wr_last),
      .data_next (wr_next),
      .bit_out   (wr_bit),
      .done      (wr_done)
   );

   master_port_rw_serial_shifter #(
      .WIDTH (DATA_W),
      .CNT_W (CntW)
   ) u_rd_shifter (
      .clk       (clk),
      .rstn      (rstn),
      .load      (rd_load),
      .load_data ('0),
      .shift_en  (rd_shift),
      .shift_in  (bus.mp_rdata),
      .last_idx  (DataLast),
      .data_next (rd_next),
      .bit_out   (rd_bit),
      .done      (rd_done)
   );

   assign unused_sh = ^{wr_next, rd_bit};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      to_cnt_d     = '0;
      wr_load      = 1'b0;
      wr_load_data = ShW'(addr_q);
      wr_shift     = 1'b0;
      rd_load      = 1'b1;
      rd_shift     = 1'b0;
      rd_capture   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StReq;
         end
         StReq: begin
            // Reloading every REQ cycle makes each retry restart from address bit 0.
            wr_load = 1'b1;
            if (bus.mp_bgnt) state_d = StAddr;
         end
         StAddr: begin
            if (!bus.mp_bgnt) begin
               state_d = StReq;
            end else begin
               wr_shift = 1'b1;
               if (wr_done) begin
                  wr_load      = 1'b1;
                  wr_load_data = ShW'(wdata_q);
                  state_d      = StWait;
               end
            end
         end
         StWait: begin
            if (to_hit) begin
               state_d = StIdle;
            end else if (!bus.mp_bgnt) begin
               state_d = StReq;
            end else if (bus.mp_ready) begin
               state_d = (wen_q == ModeRead) ? StRdata : StWdata;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StWdata: begin
            if (!bus.mp_bgnt) begin
               state_d = StReq;
            end else begin
               wr_shift = 1'b1;
               if (wr_done) state_d = StDone;
            end
         end
         StRdata: begin
            rd_load = 1'b0;
            if (to_hit) begin
               state_d = StIdle;
            end else if (!bus.mp_bgnt) begin
               state_d = StReq;
            end else if (bus.mp_rvalid) begin
               rd_shift = 1'b1;
               if (rd_done) begin
                  rd_capture = 1'b1;
                  state_d    = StDone;
               end
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         wen_q    <= ModeRead;
         rdata_q  <= '0;
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
         if (accept) begin
            addr_q  <= bus.m_addr;
            wdata_q <= bus.m_wdata;
            wen_q   <= bus.m_wen;
         end
         if (rd_capture) rdata_q <= rd_next;
      end
   end

   assign busy_bus = (state_q == StAddr) || (state_q == StWait) ||
                     (state_q == StWdata) || (state_q == StRdata);

   assign bus.m_ready  = (state_q == StIdle);
   assign bus.m_rdata  = rdata_q;
   assign bus.m_done   = (state_q == StDone);
   assign bus.m_err    = to_hit && ((state_q == StWait) || (state_q == StRdata));
   assign bus.mp_breq  = (state_q == StReq) || busy_bus;
   assign bus.mp_valid = (state_q == StAddr) || (state_q == StWdata);
   assign bus.mp_addr  = (state_q == StAddr) && wr_bit;
   assign bus.mp_wdata = (state_q == StWdata) && wr_bit;
   // Mode is presented from the address phase through the DONE cycle.
   assign bus.mp_mode  = (busy_bus || (state_q == StDone)) ? wen_q : ModeRead;

endmodule
